wieg_frame_fifo: RTL and testbench

- Downstream consumer of the Wiegand-26 decoder in the buffer PLD.
- Takes each completed 26-bit frame plus a one-cycle valid strobe, checks the leading even-parity and trailing odd-parity bits, and queues the 24-bit card number with an error flag in a small FIFO.
- Presents the FIFO head to the DSP bus byte-wide and drives an active-low interrupt while data is pending.
- Replaces the single-register overwrite scheme, so back-to-back card reads are not lost before the DSP services the interrupt.

---
 rtl/wieg_pkg.sv | 37 +++
 rtl/wieg_fifo_mem.sv | 29 ++
 rtl/wieg_frame_fifo.sv | 203 ++++++++++++++++++++
 tb/tb_wieg_frame_fifo.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wieg_pkg.sv
// Shared types and constants for the Wiegand-26 frame FIFO.
// Optional feature macro used by this slice: WIEG_PARITY_DROP_EN.
package wieg_pkg;

    localparam int WIEG_BITS = 26;
    localparam int CARD_W    = 24;

    // One queued entry: parity-error flag plus the 24-bit card number.
    typedef struct packed {
        logic              perr;
        logic [CARD_W-1:0] card;
    } wieg_entry_t;

    // Byte selects for the DSP read port.
    typedef enum logic [1:0] {
        SEL_B0   = 2'd0,
        SEL_B1   = 2'd1,
        SEL_B2   = 2'd2,
        SEL_STAT = 2'd3
    } rd_sel_e;

    // Bit positions inside the status byte.
    localparam int ST_OVF   = 7;
    localparam int ST_STALE = 6;
    localparam int ST_PERR  = 5;
    localparam int ST_PCNT  = 4;

    // Leading bit gives even parity over [25:13], trailing bit odd parity over [12:0].
    function automatic logic frame_perr(input logic [WIEG_BITS-1:0] f);
        logic pe_even;
        logic pe_odd;
        pe_even = ^f[25:13];
        pe_odd  = ^f[12:0];
        return pe_even | ~pe_odd;
    endfunction

endpackage

// File: rtl/wieg_fifo_mem.sv
// Frame storage for wieg_frame_fifo: DEPTH x 25-bit register array with one
// write port and one asynchronous read port. Storage is deliberately not reset;
// validity is tracked by the pointers and level in the parent.
module wieg_fifo_mem
    import wieg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  wieg_entry_t      wdata,
    input  logic [PTR_W-1:0] raddr,
    output wieg_entry_t      rdata
);

    wieg_entry_t mem_q [DEPTH];

    // Write the incoming entry into the addressed slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/wieg_frame_fifo.sv
// Wiegand-26 frame FIFO: parity-checks each decoded frame, queues the card
// number with its error flag, and presents the head byte-wide to the DSP with
// an active-low pending interrupt, a sticky overflow flag and a stale timeout.
// Optional feature macro: WIEG_PARITY_DROP_EN (drop bad-parity frames and
// count them instead of queuing them).
module wieg_frame_fifo
    import wieg_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int PTR_W       = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic [WIEG_BITS-1:0] frame_in,
    input  logic                 frame_vld,
    input  logic [1:0]           rd_sel,
    input  logic                 pop,
    input  logic                 clr,
    output logic [7:0]           rd_data,
    output logic [PTR_W:0]       level,
    output logic                 nIrq
);

    localparam int             CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYC);
    localparam logic [PTR_W:0] LVL_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] LVL_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0] LVL_ZERO = (PTR_W + 1)'(0);

    // State flops
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             stale_q, stale_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             nirq_q, nirq_d;
    logic [7:0]       rd_data_q, rd_data_d;
`ifdef WIEG_PARITY_DROP_EN
    logic [7:0]       perr_cnt_q, perr_cnt_d;
    logic             perr_drop_s;
`endif

    // Combinational helpers
    logic        perr_s;
    wieg_entry_t entry_s;
    wieg_entry_t head_s;
    logic        empty_s;
    logic        full_s;
    logic        frame_ok_s;
    logic        push_ok_s;
    logic        pop_ok_s;
    logic        ovf_set_s;
    logic        stale_set_s;
    logic [7:0]  status_s;
    logic [7:0]  level_ext_s;
    rd_sel_e     sel_s;

    assign perr_s       = frame_perr(frame_in);
    assign entry_s.perr = perr_s;
    assign entry_s.card = frame_in[CARD_W:1];
    assign empty_s      = (level_q == LVL_ZERO);
    assign full_s       = (level_q == LVL_FULL);
    assign sel_s        = rd_sel_e'(rd_sel);
    assign level_ext_s  = 8'(level_q);

`ifdef WIEG_PARITY_DROP_EN
    assign frame_ok_s   = frame_vld & ~perr_s;
    assign perr_drop_s  = frame_vld & perr_s;
`else
    assign frame_ok_s   = frame_vld;
`endif

    // A pop on a full FIFO frees the slot the same-cycle push uses.
    assign pop_ok_s    = pop & ~empty_s;
    assign push_ok_s   = frame_ok_s & (~full_s | pop_ok_s);
    assign ovf_set_s   = frame_ok_s & full_s & ~pop_ok_s;
    assign stale_set_s = ~empty_s & ~pop & (cnt_q == (TO_MAX - CNT_W'(1)));

    wieg_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok_s),
        .waddr (wr_ptr_q),
        .wdata (entry_s),
        .raddr (rd_ptr_q),
        .rdata (head_s)
    );

    // Next-state for pointers, level, sticky flags, timeout and interrupt.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // Set wins over a coinciding clear for both sticky flags.
        ovf_d   = ovf_set_s   | (ovf_q   & ~clr);
        stale_d = stale_set_s | (stale_q & ~clr);

        if (empty_s || pop) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q != TO_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        nirq_d = (level_d == LVL_ZERO);
    end

`ifdef WIEG_PARITY_DROP_EN
    // Saturating bad-parity counter; a drop in the clr cycle is still counted.
    always_comb begin
        perr_cnt_d = perr_cnt_q;
        if (clr) begin
            perr_cnt_d = perr_drop_s ? 8'd1 : 8'd0;
        end else if (perr_drop_s && (perr_cnt_q != 8'hFF)) begin
            perr_cnt_d = perr_cnt_q + 8'd1;
        end else begin
            perr_cnt_d = perr_cnt_q;
        end
    end
`endif

    // Read mux: head bytes (zero when empty) or the status byte.
    always_comb begin
        status_s           = 8'h00;
        status_s[ST_OVF]   = ovf_q;
        status_s[ST_STALE] = stale_q;
        status_s[ST_PERR]  = ~empty_s & head_s.perr;
`ifdef WIEG_PARITY_DROP_EN
        status_s[ST_PCNT]  = (perr_cnt_q != 8'h00);
`else
        status_s[ST_PCNT]  = 1'b0;
`endif
        status_s[2:0]      = level_ext_s[2:0];

        rd_data_d = 8'h00;
        case (sel_s)
            SEL_B0:   rd_data_d = empty_s ? 8'h00 : head_s.card[7:0];
            SEL_B1:   rd_data_d = empty_s ? 8'h00 : head_s.card[15:8];
            SEL_B2:   rd_data_d = empty_s ? 8'h00 : head_s.card[23:16];
            SEL_STAT: rd_data_d = status_s;
            default:  rd_data_d = 8'h00;
        endcase
    end

    // Register all control state and outputs; reset discards every entry.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            level_q    <= LVL_ZERO;
            ovf_q      <= 1'b0;
            stale_q    <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            nirq_q     <= 1'b1;
            rd_data_q  <= 8'h00;
`ifdef WIEG_PARITY_DROP_EN
            perr_cnt_q <= 8'h00;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            stale_q    <= stale_d;
            cnt_q      <= cnt_d;
            nirq_q     <= nirq_d;
            rd_data_q  <= rd_data_d;
`ifdef WIEG_PARITY_DROP_EN
            perr_cnt_q <= perr_cnt_d;
`endif
        end
    end

    assign rd_data = rd_data_q;
    assign level   = level_q;
    assign nIrq    = nirq_q;

endmodule

// File: tb/tb_wieg_frame_fifo.sv
// Directed bench for wieg_frame_fifo (DEPTH 4, short timeout for run time).
module tb_wieg_frame_fifo;

    localparam int TO = 64;

    logic        clk;
    logic        nReset;
    logic [25:0] frame_in;
    logic        frame_vld;
    logic [1:0]  rd_sel;
    logic        pop;
    logic        clr;
    logic [7:0]  rd_data;
    logic [2:0]  level;
    logic        nIrq;

    int tests;
    int failed;

    wieg_frame_fifo #(
        .DEPTH       (4),
        .PTR_W       (2),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .nReset    (nReset),
        .frame_in  (frame_in),
        .frame_vld (frame_vld),
        .rd_sel    (rd_sel),
        .pop       (pop),
        .clr       (clr),
        .rd_data   (rd_data),
        .level     (level),
        .nIrq      (nIrq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Build a correctly framed word around a card number.
    function automatic logic [25:0] mk_frame(input logic [23:0] card);
        logic [25:0] f;
        f     = {1'b0, card, 1'b0};
        f[25] = ^card[23:12];
        f[0]  = ~(^card[11:0]);
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [25:0] f);
        frame_in  = f;
        frame_vld = 1'b1;
        tick();
        frame_vld = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic read(input logic [1:0] sel);
        rd_sel = sel;
        tick();
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        nReset    = 1'b1;
        frame_in  = 26'h0;
        frame_vld = 1'b0;
        rd_sel    = 2'd0;
        pop       = 1'b0;
        clr       = 1'b0;

        // Reset state
        #2 nReset = 1'b0;
        #1;
        check("rst_level", {5'd0, level}, 8'h00);
        check("rst_nirq", {7'd0, nIrq}, 8'h01);
        check("rst_rd_data", rd_data, 8'h00);
        @(negedge clk);
        nReset = 1'b1;
        tick();

        // Single good frame: card 0x52AD52
        push(26'h2A5_5AA5);
        check("push1_level", {5'd0, level}, 8'h01);
        check("push1_nirq", {7'd0, nIrq}, 8'h00);
        read(2'd0); check("push1_b0", rd_data, 8'h52);
        read(2'd1); check("push1_b1", rd_data, 8'hAD);
        read(2'd2); check("push1_b2", rd_data, 8'h52);
        read(2'd3); check("push1_stat", rd_data, 8'h01);
        do_pop();
        check("pop1_level", {5'd0, level}, 8'h00);
        check("pop1_nirq", {7'd0, nIrq}, 8'h01);
        read(2'd0); check("empty_b0", rd_data, 8'h00);

        // Bad trailing parity bit
        push(26'h2A5_5AA4);
`ifdef WIEG_PARITY_DROP_EN
        check("bad_level", {5'd0, level}, 8'h00);
        read(2'd3); check("bad_stat", rd_data, 8'h10);
        do_clr();
        read(2'd3); check("bad_clr_stat", rd_data, 8'h00);
`else
        check("bad_level", {5'd0, level}, 8'h01);
        read(2'd3); check("bad_stat", rd_data, 8'h21);
        read(2'd2); check("bad_b2", rd_data, 8'h52);
        do_pop();
        check("bad_pop_level", {5'd0, level}, 8'h00);
`endif

        // Five frames into a four-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            push(mk_frame({3{8'(i * 8'h11)}}));
        end
        check("ovf_level", {5'd0, level}, 8'h04);
        read(2'd3); check("ovf_stat", rd_data, 8'h84);
        read(2'd0); check("ovf_rd0", rd_data, 8'h11);
        do_pop();
        read(2'd0); check("ovf_rd1", rd_data, 8'h22);
        do_pop();
        read(2'd0); check("ovf_rd2", rd_data, 8'h33);
        do_pop();
        read(2'd2); check("ovf_rd3", rd_data, 8'h44);
        do_pop();
        check("ovf_drain_level", {5'd0, level}, 8'h00);
        read(2'd3); check("ovf_sticky", rd_data, 8'h80);
        do_clr();
        read(2'd3); check("ovf_clr", rd_data, 8'h00);

        // Pop on empty is ignored
        do_pop();
        check("empty_pop_level", {5'd0, level}, 8'h00);

        // Simultaneous push and pop on empty: only the push lands
        frame_in  = mk_frame(24'h0000B1);
        frame_vld = 1'b1;
        pop       = 1'b1;
        tick();
        frame_vld = 1'b0;
        pop       = 1'b0;
        check("emp_pp_level", {5'd0, level}, 8'h01);
        read(2'd0); check("emp_pp_b0", rd_data, 8'hB1);
        do_pop();

        // Full FIFO, pop and push together
        for (int i = 1; i <= 4; i++) begin
            push(mk_frame({16'h0000, 8'(8'hA0 + i)}));
        end
        frame_in  = mk_frame(24'h0000A5);
        frame_vld = 1'b1;
        pop       = 1'b1;
        tick();
        frame_vld = 1'b0;
        pop       = 1'b0;
        check("full_pp_level", {5'd0, level}, 8'h04);
        read(2'd3); check("full_pp_stat", rd_data, 8'h04);
        for (int i = 2; i <= 5; i++) begin
            read(2'd0);
            check("full_pp_order", rd_data, 8'(8'hA0 + i));
            do_pop();
        end
        check("full_pp_drain", {5'd0, level}, 8'h00);

        // Stale timeout with one entry left unread
        rd_sel = 2'd3;
        push(mk_frame(24'h0000D1));
        repeat (TO - 4) tick();
        check("stale_early", rd_data, 8'h01);
        repeat (8) tick();
        check("stale_set", rd_data, 8'h41);
        do_pop();
        check("stale_pop_nirq", {7'd0, nIrq}, 8'h01);
        check("stale_pop_level", {5'd0, level}, 8'h00);
        tick();
        check("stale_sticky", rd_data, 8'h40);
        do_clr();
        tick();
        check("stale_clr", rd_data, 8'h00);

        // Asynchronous reset with three entries queued
        push(mk_frame(24'h0000C1));
        push(mk_frame(24'h0000C2));
        push(mk_frame(24'h0000C3));
        check("mid_level", {5'd0, level}, 8'h03);
        read(2'd0); check("mid_b0", rd_data, 8'hC1);
        #2 nReset = 1'b0;
        #1;
        check("mid_rst_level", {5'd0, level}, 8'h00);
        check("mid_rst_nirq", {7'd0, nIrq}, 8'h01);
        check("mid_rst_data", rd_data, 8'h00);
        @(negedge clk);
        nReset = 1'b1;
        read(2'd3); check("mid_rst_stat", rd_data, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
